alu_iter_exec: RTL



---
 rtl/alu_iter_exec.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/alu_iter_exec.sv
// Execute-stage ALU: single-cycle combinational ops plus an iterative shift-add MUL with stall/done handshake.
// Optional build macro: ALU_MUL_RADIX4_EN selects a radix-4 multiplier step (16 iterations instead of 32).
module alu_iter_exec #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic [3:0]      ALUSignal_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic            hold_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] result_o,
    output logic            done_o,
    output logic            stall_o
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_SLT = 4'd4;
    localparam logic [3:0] OP_MUL = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_SL  = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
    localparam logic [3:0] OP_SRL = 4'd9;

`ifdef ALU_MUL_RADIX4_EN
    localparam logic [5:0] LAST_STEP = 6'd15;
`else
    localparam logic [5:0] LAST_STEP = 6'd31;
`endif

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e          state, state_next;
    logic [XLEN-1:0] opa, opb, acc;
    logic [5:0]      cnt;
    logic [XLEN-1:0] comb_res;
    logic [XLEN-1:0] partial;
    logic [XLEN-1:0] opa_next, opb_next;
    logic            mul_start;
    logic [4:0]      shamt;

    assign shamt = src2_i[4:0];

    always_comb begin
        comb_res = '0;
        case (ALUSignal_i)
            OP_ADD: comb_res = src1_i + src2_i;
            OP_SUB: comb_res = src1_i - src2_i;
            OP_AND: comb_res = src1_i & src2_i;
            OP_OR:  comb_res = src1_i | src2_i;
            OP_SLT: comb_res = {{(XLEN-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            OP_XOR: comb_res = src1_i ^ src2_i;
            OP_SL:  comb_res = src1_i << shamt;
            OP_SRA: comb_res = $unsigned($signed(src1_i) >>> shamt);
            OP_SRL: comb_res = src1_i >> shamt;
            default: comb_res = '0;
        endcase
    end

    // One multiplier iteration: partial product for the low operand-B digit, then realign operands.
    always_comb begin
`ifdef ALU_MUL_RADIX4_EN
        partial  = (opb[0] ? opa : '0) + (opb[1] ? {opa[XLEN-2:0], 1'b0} : '0);
        opa_next = {opa[XLEN-3:0], 2'b00};
        opb_next = {2'b00, opb[XLEN-1:2]};
`else
        partial  = opb[0] ? opa : '0;
        opa_next = {opa[XLEN-2:0], 1'b0};
        opb_next = {1'b0, opb[XLEN-1:1]};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        result_o   = '0;
        done_o     = 1'b0;
        stall_o    = 1'b0;
        mul_start  = 1'b0;
        case (state)
            IDLE: begin
                if (valid_i) begin
                    if (ALUSignal_i == OP_MUL) begin
                        if (!flush_i) begin
                            stall_o    = 1'b1;
                            mul_start  = 1'b1;
                            state_next = BUSY;
                        end
                    end else begin
                        result_o = comb_res;
                        done_o   = 1'b1;
                    end
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (flush_i) begin
                    state_next = IDLE;
                end else if (cnt == LAST_STEP) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                result_o = acc;
                done_o   = 1'b1;
                if (flush_i || !hold_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa <= '0;
            opb <= '0;
            acc <= '0;
            cnt <= '0;
        end else if (mul_start) begin
            opa <= src1_i;
            opb <= src2_i;
            acc <= '0;
            cnt <= '0;
        end else if (state == BUSY && !flush_i) begin
            acc <= acc + partial;
            opa <= opa_next;
            opb <= opb_next;
            cnt <= cnt + 6'd1;
        end
    end

endmodule
